// File: rtl/port_spi_master.sv
// Port-mapped SPI master (mode 0, MSB first) with DATA/STATUS/DIV/CS registers at BASE_PORT..+3.
// Optional receive path (miso capture, rx byte, rx_valid) enabled by defining PORT_SPI_RX_EN.
module port_spi_master #(
  parameter logic [7:0] BASE_PORT = 8'h10,
  parameter int         DIV_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic [3:0] cs_n
);

`ifdef PORT_SPI_RX_EN
  localparam logic RX_EN = 1'b1;
`else
  localparam logic RX_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 write_q;
  logic                 read_q;
  logic [7:0]           port_q;
  logic                 write_act;
  logic                 read_act;

  logic [7:0]           offset;
  logic                 owned;
  logic                 sel_data;
  logic                 sel_div;
  logic                 sel_cs;
  logic                 data_wr;
  logic                 div_wr;
  logic                 cs_wr;
  logic                 data_rd;

  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_cap;
  logic [DIV_WIDTH-1:0] div_wr_val;
  logic [7:0]           div_rd_val;
  logic [DIV_WIDTH-1:0] cnt;
  logic [4:0]           half_cnt;
  logic                 half_done;
  logic                 half_end;

  logic [7:0]           shreg;
  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic [3:0]           cs_reg;
  logic                 sclk_reg;
  logic                 mosi_reg;

  logic                 busy;
  logic                 start;
  logic                 done;

  // An access is taken only on the first cycle of a strobe run, or when the
  // address moves while the strobe is held.
  assign write_act = write_strobe && (!write_q || (port_id != port_q));
  assign read_act  = read_strobe  && (!read_q  || (port_id != port_q));

  assign offset   = port_id - BASE_PORT;
  assign owned    = (offset[7:2] == 6'd0);
  assign sel_data = owned && (offset[1:0] == 2'd0);
  assign sel_div  = owned && (offset[1:0] == 2'd2);
  assign sel_cs   = owned && (offset[1:0] == 2'd3);

  assign data_wr  = write_act && sel_data;
  assign div_wr   = write_act && sel_div;
  assign cs_wr    = write_act && sel_cs;
  assign data_rd  = read_act  && sel_data;

  generate
    if (DIV_WIDTH > 8) begin : g_div_wide
      assign div_wr_val = {{(DIV_WIDTH-8){1'b0}}, out_port};
      assign div_rd_val = div_reg[7:0];
    end else if (DIV_WIDTH == 8) begin : g_div_byte
      assign div_wr_val = out_port;
      assign div_rd_val = div_reg;
    end else begin : g_div_narrow
      assign div_wr_val = out_port[DIV_WIDTH-1:0];
      assign div_rd_val = {{(8-DIV_WIDTH){1'b0}}, div_reg};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      port_q  <= 8'h00;
    end else begin
      write_q <= write_strobe;
      read_q  <= read_strobe;
      port_q  <= port_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign half_done = (half_cnt == 5'd16);
  assign half_end  = (cnt == div_cap);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_wr)   state_nxt = SHIFT;
      SHIFT:   if (half_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    start = data_wr;
      SHIFT:   busy  = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= DIV_WIDTH'(3);
      cs_reg  <= 4'hF;
    end else begin
      if (div_wr) div_reg <= div_wr_val;
      if (cs_wr)  cs_reg  <= out_port[3:0];
    end
  end

  // Shift engine: a half-period ends when cnt reaches the divider captured at
  // start; rising sclk samples miso, falling sclk presents the next bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= 8'h00;
      sclk_reg <= 1'b0;
      mosi_reg <= 1'b0;
      cnt      <= '0;
      half_cnt <= 5'd0;
      div_cap  <= '0;
    end else if (start) begin
      shreg    <= out_port;
      mosi_reg <= out_port[7];
      sclk_reg <= 1'b0;
      cnt      <= '0;
      half_cnt <= 5'd0;
      div_cap  <= div_reg;
    end else if ((state == SHIFT) && !half_done) begin
      if (half_end) begin
        cnt      <= '0;
        half_cnt <= half_cnt + 5'd1;
        sclk_reg <= ~sclk_reg;
        if (!sclk_reg) begin
          shreg <= {shreg[6:0], miso & RX_EN};
        end else if (half_cnt != 5'd15) begin
          mosi_reg <= shreg[7];
        end
      end else begin
        cnt <= cnt + DIV_WIDTH'(1);
      end
    end
  end

  // Completion sets rx_valid even if a DATA read lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (done) begin
      rx_byte  <= RX_EN ? shreg : 8'h00;
      rx_valid <= RX_EN;
    end else if (start || data_rd) begin
      rx_valid <= 1'b0;
    end
  end

  always_comb begin
    in_port = 8'h00;
    if (owned) begin
      case (offset[1:0])
        2'd0:    in_port = RX_EN ? rx_byte : 8'h00;
        2'd1:    in_port = {6'd0, rx_valid & RX_EN, busy};
        2'd2:    in_port = div_rd_val;
        default: in_port = {4'h0, cs_reg};
      endcase
    end
  end

  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign cs_n = cs_reg;

endmodule

// File: tb/tb_port_spi_master.sv
// Directed bench for port_spi_master; expectations follow the PORT_SPI_RX_EN build setting.
module tb_port_spi_master;

  localparam logic [7:0] BASE = 8'h10;
`ifdef PORT_SPI_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [3:0] cs_n;

  logic       loop_en;
  logic       miso_tie;
  int         rise_n;
  logic [7:0] mosi_cap;
  int         pass_n;
  int         total_n;

  port_spi_master #(.BASE_PORT(BASE), .DIV_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .out_port     (out_port),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .cs_n         (cs_n)
  );

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_tie;

  always @(posedge sclk) begin
    mosi_cap = {mosi_cap[6:0], mosi};
    rise_n   = rise_n + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    port_id = p; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] p, output logic [7:0] d);
    @(negedge clk);
    port_id = p; read_strobe = 1'b1;
    #1 d = in_port;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  // Starts a transfer and counts busy cycles and sclk toggles until busy drops;
  // optionally issues a DATA read on busy cycle read_at.
  task automatic xfer(input logic [7:0] d, input int read_at, output int busy_n, output int tog_n);
    logic prev;
    rise_n = 0; mosi_cap = 8'h00;
    @(negedge clk);
    port_id = BASE; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    busy_n = 0; tog_n = 0; prev = sclk;
    for (int i = 0; i < 400; i++) begin
      port_id = BASE + 8'd1; read_strobe = 1'b0;
      #1;
      if (!in_port[0]) break;
      busy_n++;
      if (sclk !== prev) tog_n++;
      prev = sclk;
      if (busy_n == read_at) begin
        port_id = BASE; read_strobe = 1'b1;
      end
      @(negedge clk);
    end
    read_strobe = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int bn, tn;
    pass_n = 0; total_n = 0;
    reset = 1'b1; port_id = 8'h00; write_strobe = 1'b0; out_port = 8'h00;
    read_strobe = 1'b0; loop_en = 1'b0; miso_tie = 1'b0;
    rise_n = 0; mosi_cap = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sclk", 16'(sclk), 16'h0);
    check("rst_mosi", 16'(mosi), 16'h0);
    check("rst_cs_n", 16'(cs_n), 16'hF);
    reset = 1'b0;
    io_read(BASE + 8'd1, rd); check("rst_status", 16'(rd), 16'h00);
    io_read(BASE + 8'd2, rd); check("rst_div",    16'(rd), 16'h03);
    io_read(BASE,        rd); check("rst_data",   16'(rd), 16'h00);
    io_read(BASE + 8'd3, rd); check("rst_cs_rd",  16'(rd), 16'h0F);

    // DIV=3 loopback transfer of A5
    loop_en = 1'b1;
    xfer(8'hA5, 0, bn, tn);
    check("a5_busy",  16'(bn), 16'd66);
    check("a5_rises", 16'(rise_n), 16'd8);
    check("a5_mosi",  16'(mosi_cap), 16'hA5);
    check("a5_togs",  16'(tn), 16'd16);
    check("a5_sclk_idle", 16'(sclk), 16'h0);
    io_read(BASE + 8'd1, rd); check("a5_status", 16'(rd), RX ? 16'h02 : 16'h00);
    io_read(BASE,        rd); check("a5_data",   16'(rd), RX ? 16'hA5 : 16'h00);
    io_read(BASE + 8'd1, rd); check("a5_status_clr", 16'(rd), 16'h00);

    // Held strobe, write while busy, and DIV change mid-transfer
    rise_n = 0; mosi_cap = 8'h00; bn = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      write_strobe = 1'b0; port_id = BASE + 8'd1;
      #1;
      if (in_port[0]) bn++;
      case (c)
        0, 1: begin port_id = BASE;        out_port = 8'h3C; write_strobe = 1'b1; end
        10:   begin port_id = BASE;        out_port = 8'hFF; write_strobe = 1'b1; end
        20:   begin port_id = BASE + 8'd2; out_port = 8'h00; write_strobe = 1'b1; end
        default: ;
      endcase
    end
    write_strobe = 1'b0;
    check("3c_busy",  16'(bn), 16'd66);
    check("3c_rises", 16'(rise_n), 16'd8);
    check("3c_mosi",  16'(mosi_cap), 16'h3C);
    io_read(BASE,        rd); check("3c_data", 16'(rd), RX ? 16'h3C : 16'h00);
    io_read(BASE + 8'd2, rd); check("div0_rd", 16'(rd), 16'h00);

    // DIV=0, miso tied high, DATA read collides with completion
    loop_en = 1'b0; miso_tie = 1'b1;
    xfer(8'h5A, 18, bn, tn);
    check("d0_busy",  16'(bn), 16'd18);
    check("d0_togs",  16'(tn), 16'd16);
    check("d0_mosi",  16'(mosi_cap), 16'h5A);
    check("d0_set_wins", 16'(in_port), RX ? 16'h02 : 16'h00);
    io_read(BASE,        rd); check("d0_data",   16'(rd), RX ? 16'hFF : 16'h00);
    io_read(BASE + 8'd1, rd); check("d0_status", 16'(rd), 16'h00);

    // Strobe held across a port change: DIV and CS taken, repeat on CS ignored
    @(negedge clk); port_id = BASE + 8'd2; out_port = 8'h07; write_strobe = 1'b1;
    @(negedge clk); port_id = BASE + 8'd3; out_port = 8'h0A;
    @(negedge clk); out_port = 8'h05;
    @(negedge clk); write_strobe = 1'b0;
    #1 check("held_cs_n", 16'(cs_n), 16'hA);
    io_read(BASE + 8'd2, rd); check("held_div", 16'(rd), 16'h07);

    // CS register and address decode boundaries
    io_write(BASE + 8'd3, 8'h0E);
    #1 check("cs_n_e", 16'(cs_n), 16'hE);
    io_read(BASE + 8'd3, rd); check("cs_rd",    16'(rd), 16'h0E);
    io_read(8'h20,       rd); check("rd_20",    16'(rd), 16'h00);
    io_read(8'h14,       rd); check("rd_above", 16'(rd), 16'h00);
    io_read(8'h0F,       rd); check("rd_below", 16'(rd), 16'h00);

    // Reset 20 cycles into a DIV=5 transfer
    io_write(BASE + 8'd2, 8'h05);
    io_write(BASE, 8'h81);
    repeat (19) @(negedge clk);
    port_id = BASE + 8'd1;
    #1 check("mid_busy", 16'(in_port), 16'h01);
    check("mid_sclk", 16'(sclk), 16'h1);
    #1 reset = 1'b1;
    #1 check("ar_sclk",   16'(sclk), 16'h0);
    check("ar_mosi",   16'(mosi), 16'h0);
    check("ar_cs_n",   16'(cs_n), 16'hF);
    check("ar_status", 16'(in_port), 16'h00);
    port_id = BASE + 8'd2;
    #1 check("ar_div", 16'(in_port), 16'h03);
    @(negedge clk); reset = 1'b0;
    repeat (150) @(negedge clk);
    port_id = BASE + 8'd1;
    #1 check("ar_no_rx", 16'(in_port), 16'h00);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/port_spi_master.md
PORT_SPI_MASTER -- requirements
Module: port_spi_master

Interface
REQ-001 Parameter BASE_PORT, default 8'h10, first of four consecutive port_id addresses owned by the block.
REQ-002 Parameter DIV_WIDTH, default 8, width of the SCLK divider register.
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 port_id  input  8  port address from the processor bus.
REQ-006 write_strobe  input  1  write qualifier; may stay high for consecutive cycles per access.
REQ-007 out_port  input  8  write data.
REQ-008 read_strobe  input  1  read qualifier; may stay high for consecutive cycles per access.
REQ-009 in_port  output  8  read data.
REQ-010 sclk  output  1  SPI clock.
REQ-011 mosi  output  1  SPI data out.
REQ-012 miso  input  1  SPI data in.
REQ-013 cs_n  output  4  active-low chip selects.

Function
REQ-014 Register map at BASE_PORT+n: n=0 DATA (W: tx byte/start, R: rx byte); n=1 STATUS (R: bit0 busy, bit1 rx_valid, others 0); n=2 DIV (R/W); n=3 CS (R/W, low nibble drives cs_n, high nibble reads 0).
REQ-015 An access is acted on once, in the first cycle of a strobe run: strobe high and (strobe low previous cycle or port_id changed).
REQ-016 in_port is combinational from port_id and registered state; it is 8'h00 when port_id is outside the four owned addresses.
REQ-017 The FSM has states IDLE, SHIFT, DONE; busy is 1 in SHIFT and DONE.
REQ-018 IDLE: a DATA write loads the shift register with out_port, clears rx_valid, sets mosi to bit 7, and enters SHIFT on the next edge.
REQ-019 A DATA write while busy is ignored; the shift register and transfer are unaffected.
REQ-020 SHIFT: 16 half-periods of (DIV+1) clk cycles each; sclk idles low (mode 0), MSB first.
REQ-021 On each sclk rising edge, miso is sampled into the LSB. On each falling edge except the last, mosi advances to the next bit.
REQ-022 After the 16th half-period, sclk is low; the FSM enters DONE for exactly one cycle, latches rx byte, sets rx_valid, then returns to IDLE.
REQ-023 Transfer length in clk cycles from write edge to busy fall = 16*(DIV+1)+2.
REQ-024 A DATA read clears rx_valid. If a read and the DONE set occur in the same cycle, set wins.
REQ-025 DIV writes take effect at the next transfer start; the divider value is captured at the IDLE->SHIFT transition.
REQ-026 DIV=0 is legal: sclk toggles every clk cycle.
REQ-027 cs_n changes only on CS writes and never automatically; a CS write mid-transfer is applied immediately.

Reset
REQ-028 Reset clears the FSM to IDLE, sclk=0, mosi=0, shift register=0, rx byte=0, rx_valid=0, busy=0.
REQ-029 Reset sets DIV to 3 and cs_n to 4'hF; strobe edge-history registers are cleared.
REQ-030 Reset asserted mid-transfer aborts the transfer immediately, with no DONE cycle and no rx_valid.

Configuration
REQ-031 Macro PORT_SPI_RX_EN defined: miso capture, rx byte, and rx_valid are implemented per REQ-021/022/024.
REQ-032 Macro PORT_SPI_RX_EN undefined: miso is ignored, DATA reads return 8'h00, and STATUS bit1 reads 0; TX timing is identical.

Verification
REQ-033 DIV=3; write DATA=8'hA5, with miso looped to mosi -> mosi shows 1,0,1,0,0,1,0,1; busy high for 66 cycles; DATA read returns 8'hA5, rx_valid=1, then 0 after the read.
REQ-034 Write DATA=8'h3C with write_strobe held 2 cycles, then a second write of 8'hFF at cycle 10 -> exactly one transfer of 8'h3C occurs; 8'hFF is dropped.
REQ-035 DIV=0, miso tied 1 -> sclk toggles each cycle; busy is high for 18 cycles; rx byte is 8'hFF.
REQ-036 CS write 8'h0E, then read port BASE_PORT+3 -> cs_n=4'hE and in_port=8'h0E; read port 8'h20 -> in_port=8'h00.
REQ-037 Assert reset at cycle 20 of a transfer -> sclk=0, busy=0, cs_n=4'hF, and DIV=3 immediately; no rx_valid.
REQ-038 With PORT_SPI_RX_EN undefined, repeat REQ-033 -> identical mosi and sclk waveforms; DATA read returns 8'h00.
